apb_fsm_controller: RTL and testbench

- Downstream stage of the AHB slave interface in the AHB-to-APB bridge.
- Consumes the pipelined AHB address, data and control (valid, Haddr/Haddr1/Haddr2, Hwdata/Hwdata1/Hwdata2, Hwrite/Hwritereg, tempselx).
- Sequences APB SETUP/ENABLE phases, including back-to-back pipelined writes, and drives all APB outputs from registers.
- Stalls the AHB master through Hreadyout.

---
 rtl/apb_bridge_pkg.sv | 24 ++
 rtl/apb_fsm_controller.sv | 132 +++++++++++++
 tb/tb_apb_fsm_controller.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the AHB-to-APB bridge: FSM state encoding,
// slave-select one-hot constants and default bus widths.
package apb_bridge_pkg;

   localparam int ADDR_W_DEFAULT = 32;
   localparam int DATA_W_DEFAULT = 32;
   localparam int NSLV           = 3;

   localparam logic [NSLV-1:0] SLV0 = 3'b001;
   localparam logic [NSLV-1:0] SLV1 = 3'b010;
   localparam logic [NSLV-1:0] SLV2 = 3'b100;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WWAIT,
      ST_READ,
      ST_WRITE,
      ST_WRITEP,
      ST_RENABLE,
      ST_WENABLE,
      ST_WENABLEP
   } apb_state_t;

endpackage

// File: rtl/apb_fsm_controller.sv
// APB sequencer of the AHB-to-APB bridge: SETUP/ENABLE phases from the pipelined
// AHB controls, all APB outputs registered. Define APB_PREADY_EN to add Pready wait states.
module apb_fsm_controller
   import apb_bridge_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT,
   parameter int DATA_W = DATA_W_DEFAULT
) (
   input  logic              Hclk,
   input  logic              Hreset,
   input  logic              valid,
   input  logic              Hwrite,
   input  logic              Hwritereg,
   input  logic [ADDR_W-1:0] Haddr,
   input  logic [ADDR_W-1:0] Haddr1,
   input  logic [ADDR_W-1:0] Haddr2,
   input  logic [DATA_W-1:0] Hwdata,
   input  logic [DATA_W-1:0] Hwdata1,
   input  logic [DATA_W-1:0] Hwdata2,
   input  logic [NSLV-1:0]   tempselx,
   input  logic [DATA_W-1:0] Prdata,
`ifdef APB_PREADY_EN
   input  logic              Pready,
`endif
   output logic [NSLV-1:0]   Pselx,
   output logic              Penable,
   output logic              Pwrite,
   output logic [ADDR_W-1:0] Paddr,
   output logic [DATA_W-1:0] Pwdata,
   output logic              Hreadyout,
   output logic [DATA_W-1:0] Hrdata
);

   apb_state_t      state;
   apb_state_t      nxt_state;
   apb_state_t      idle_dest;
   logic [NSLV-1:0] sel_d1;
   logic [NSLV-1:0] sel_d2;
   logic            enable_go;
   logic            stall;
   logic            unused_inputs;

`ifdef APB_PREADY_EN
   assign enable_go = Pready;
`else
   assign enable_go = 1'b1;
`endif

   assign Hrdata        = Prdata;
   assign unused_inputs = ^Hwdata2;

   // Shared decode for IDLE and the single-cycle ENABLE states (no bubble).
   assign idle_dest = !valid ? ST_IDLE : (Hwrite ? ST_WWAIT : ST_READ);

   always_comb begin
      // NOTE: defaults first so every path assigns both outputs; no latch is inferred.
      nxt_state = state;
      stall     = 1'b0;
      case (state)
         ST_IDLE:    nxt_state = idle_dest;
         ST_WWAIT:   nxt_state = valid ? ST_WRITEP : ST_WRITE;
         ST_READ:    nxt_state = ST_RENABLE;
         ST_WRITE:   nxt_state = valid ? ST_WENABLEP : ST_WENABLE;
         ST_WRITEP:  nxt_state = ST_WENABLEP;
         ST_RENABLE, ST_WENABLE: begin
            if (enable_go) nxt_state = idle_dest;
            else           stall     = 1'b1;
         end
         ST_WENABLEP: begin
            if (!enable_go)     stall     = 1'b1;
            else if (!Hwritereg) nxt_state = ST_READ;
            else if (valid)      nxt_state = ST_WRITEP;
            else                 nxt_state = ST_WRITE;
         end
         default:    nxt_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge Hclk) begin
      if (Hreset) begin
         state     <= ST_IDLE;
         Pselx     <= '0;
         Penable   <= 1'b0;
         Pwrite    <= 1'b0;
         Paddr     <= '0;
         Pwdata    <= '0;
         Hreadyout <= 1'b1;
         sel_d1    <= '0;
         sel_d2    <= '0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values of the others.
         state  <= nxt_state;
         sel_d1 <= tempselx;
         sel_d2 <= sel_d1;
         // Outputs are loaded on the edge that enters their state.
         case (nxt_state)
            ST_READ: begin
               Paddr     <= Haddr;
               Pwrite    <= 1'b0;
               Pselx     <= tempselx;
               Penable   <= 1'b0;
               Hreadyout <= 1'b0;
            end
            ST_WRITE, ST_WRITEP: begin
               // After a pipelined write the second transfer is one stage further back.
               if (state == ST_WENABLEP) begin
                  Paddr  <= Haddr2;
                  Pwdata <= Hwdata1;
                  Pselx  <= sel_d2;
               end else begin
                  Paddr  <= Haddr1;
                  Pwdata <= Hwdata;
                  Pselx  <= sel_d1;
               end
               Pwrite    <= 1'b1;
               Penable   <= 1'b0;
               Hreadyout <= (nxt_state == ST_WRITE);
            end
            ST_RENABLE, ST_WENABLE, ST_WENABLEP: begin
               Penable   <= 1'b1;
               Hreadyout <= !stall;
            end
            default: begin
               Pselx     <= '0;
               Penable   <= 1'b0;
               Hreadyout <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Scoreboard bench for apb_fsm_controller: expected APB phases are queued with the
// stimulus and a negedge monitor compares every cycle where Pselx is nonzero.
module tb_apb_fsm_controller;
   import apb_bridge_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;

   typedef struct packed {
      logic [NSLV-1:0] sel;
      logic            en;
      logic            wr;
      logic [AW-1:0]   addr;
      logic [DW-1:0]   wdata;
      logic            rdy;
   } phase_t;

   logic            Hclk = 1'b0;
   logic            Hreset, valid, Hwrite, Hwritereg;
   logic [AW-1:0]   Haddr, Haddr1, Haddr2;
   logic [DW-1:0]   Hwdata, Hwdata1, Hwdata2, Prdata;
   logic [NSLV-1:0] tempselx;
   logic [NSLV-1:0] Pselx;
   logic            Penable, Pwrite, Hreadyout;
   logic [AW-1:0]   Paddr;
   logic [DW-1:0]   Pwdata, Hrdata;
`ifdef APB_PREADY_EN
   logic            Pready;
`endif

   phase_t exp_q[$];
   logic   chk_q[$];
   int     checks = 0;
   int     errors = 0;

   always #5 Hclk = ~Hclk;

   apb_fsm_controller dut (
      .Hclk(Hclk), .Hreset(Hreset), .valid(valid), .Hwrite(Hwrite), .Hwritereg(Hwritereg),
      .Haddr(Haddr), .Haddr1(Haddr1), .Haddr2(Haddr2),
      .Hwdata(Hwdata), .Hwdata1(Hwdata1), .Hwdata2(Hwdata2),
      .tempselx(tempselx), .Prdata(Prdata),
`ifdef APB_PREADY_EN
      .Pready(Pready),
`endif
      .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite), .Paddr(Paddr),
      .Pwdata(Pwdata), .Hreadyout(Hreadyout), .Hrdata(Hrdata)
   );

   // Upstream AHB slave pipeline delays.
   always @(posedge Hclk) begin
      if (Hreset) begin
         Haddr1 <= '0; Haddr2 <= '0; Hwdata1 <= '0; Hwdata2 <= '0; Hwritereg <= 1'b0;
      end else begin
         Haddr1 <= Haddr; Haddr2 <= Haddr1;
         Hwdata1 <= Hwdata; Hwdata2 <= Hwdata1;
         Hwritereg <= Hwrite;
      end
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [NSLV-1:0] s, input logic en, input logic wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic chk_d, input logic rdy);
      exp_q.push_back(phase_t'{s, en, wr, a, d, rdy});
      chk_q.push_back(chk_d);
   endtask

   task automatic drv(input logic v, input logic w, input logic [AW-1:0] a,
                      input logic [NSLV-1:0] s, input logic [DW-1:0] d);
      valid = v; Hwrite = w; Haddr = a; tempselx = s; Hwdata = d;
      @(posedge Hclk);
      #1;
   endtask

   task automatic check_reset_values();
      check("rst_pselx",   Pselx,     3'b000);
      check("rst_penable", Penable,   1'b0);
      check("rst_pwrite",  Pwrite,    1'b0);
      check("rst_paddr",   Paddr,     32'h0);
      check("rst_pwdata",  Pwdata,    32'h0);
      check("rst_hready",  Hreadyout, 1'b1);
   endtask

   // Monitor: one scoreboard entry per cycle with an active select.
   initial begin
      phase_t act, exp;
      logic   chk_d;
      forever begin
         @(negedge Hclk);
         check("penable_implies_psel", (Penable && (Pselx == '0)), 1'b0);
         if (Pselx != '0) begin
            if (exp_q.size() == 0) begin
               check("unexpected_phase", Pselx, 3'b000);
            end else begin
               exp   = exp_q.pop_front();
               chk_d = chk_q.pop_front();
               act   = phase_t'{Pselx, Penable, Pwrite, Paddr, Pwdata, Hreadyout};
               if (!chk_d) act.wdata = exp.wdata;
               check("apb_phase", act, exp);
            end
         end
      end
   end

   initial begin
      Hreset = 1'b1; valid = 1'b0; Hwrite = 1'b0; Haddr = '0; Hwdata = '0;
      tempselx = '0; Prdata = '0;
`ifdef APB_PREADY_EN
      Pready = 1'b1;
`endif
      repeat (2) @(posedge Hclk);
      #1;
      Hreset = 1'b0;
      check_reset_values();

      Prdata = 32'hCAFE_F00D; #1;
      check("hrdata_pass0", Hrdata, 32'hCAFE_F00D);
      Prdata = 32'h0123_4567; #1;
      check("hrdata_pass1", Hrdata, 32'h0123_4567);

      // Single read
      push(SLV0, 1'b0, 1'b0, 32'h8000_0010, 32'h0, 1'b0, 1'b0);
      push(SLV0, 1'b1, 1'b0, 32'h8000_0010, 32'h0, 1'b0, 1'b1);
      drv(1'b1, 1'b0, 32'h8000_0010, SLV0, 32'h0);
      drv(1'b0, 1'b0, 32'h8000_0010, SLV0, 32'h0);
      drv(1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
      check("read_idle_psel",   Pselx,     3'b000);
      check("read_idle_hready", Hreadyout, 1'b1);

      // Single write
      push(SLV1, 1'b0, 1'b1, 32'h8400_0004, 32'hDEAD_BEEF, 1'b1, 1'b1);
      push(SLV1, 1'b1, 1'b1, 32'h8400_0004, 32'hDEAD_BEEF, 1'b1, 1'b1);
      drv(1'b1, 1'b1, 32'h8400_0004, SLV1, 32'h0);
      check("wwait_no_psel", Pselx, 3'b000);
      drv(1'b0, 1'b0, 32'h8400_0004, SLV1, 32'hDEAD_BEEF);
      drv(1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
      drv(1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
      check("write_idle_penable", Penable, 1'b0);

      // Back-to-back writes, same slave
      push(SLV2, 1'b0, 1'b1, 32'h8800_0000, 32'h1111_AAAA, 1'b1, 1'b0);
      push(SLV2, 1'b1, 1'b1, 32'h8800_0000, 32'h1111_AAAA, 1'b1, 1'b1);
      push(SLV2, 1'b0, 1'b1, 32'h8800_0004, 32'h2222_BBBB, 1'b1, 1'b1);
      push(SLV2, 1'b1, 1'b1, 32'h8800_0004, 32'h2222_BBBB, 1'b1, 1'b1);
      drv(1'b1, 1'b1, 32'h8800_0000, SLV2, 32'h0);
      drv(1'b1, 1'b1, 32'h8800_0004, SLV2, 32'h1111_AAAA);
      drv(1'b0, 1'b1, 32'h8800_0004, SLV2, 32'h2222_BBBB);
      repeat (3) drv(1'b0, 1'b0, 32'h0, 3'b000, 32'h0);

      // Back-to-back writes to different slaves; stalled cycle carries decoys
      push(SLV0, 1'b0, 1'b1, 32'h8000_0100, 32'hA1A1_0001, 1'b1, 1'b0);
      push(SLV0, 1'b1, 1'b1, 32'h8000_0100, 32'hA1A1_0001, 1'b1, 1'b1);
      push(SLV1, 1'b0, 1'b1, 32'h8400_0100, 32'hB2B2_0002, 1'b1, 1'b1);
      push(SLV1, 1'b1, 1'b1, 32'h8400_0100, 32'hB2B2_0002, 1'b1, 1'b1);
      drv(1'b1, 1'b1, 32'h8000_0100, SLV0, 32'h0);
      drv(1'b1, 1'b1, 32'h8400_0100, SLV1, 32'hA1A1_0001);
      drv(1'b0, 1'b1, 32'h0, 3'b000, 32'hB2B2_0002);
      repeat (3) drv(1'b0, 1'b0, 32'h0, 3'b000, 32'h0);

      // Write followed immediately by read
      push(SLV1, 1'b0, 1'b1, 32'h8400_0040, 32'h5555_AAAA, 1'b1, 1'b0);
      push(SLV1, 1'b1, 1'b1, 32'h8400_0040, 32'h5555_AAAA, 1'b1, 1'b1);
      push(SLV0, 1'b0, 1'b0, 32'h8000_0020, 32'h0, 1'b0, 1'b0);
      push(SLV0, 1'b1, 1'b0, 32'h8000_0020, 32'h0, 1'b0, 1'b1);
      drv(1'b1, 1'b1, 32'h8400_0040, SLV1, 32'h0);
      drv(1'b1, 1'b0, 32'h8000_0020, SLV0, 32'h5555_AAAA);
      drv(1'b1, 1'b0, 32'h8000_0020, SLV0, 32'h0);
      drv(1'b0, 1'b0, 32'h8000_0020, SLV0, 32'h0);
      repeat (2) drv(1'b0, 1'b0, 32'h0, 3'b000, 32'h0);

      // Read accepted during RENABLE without a bubble
      push(SLV0, 1'b0, 1'b0, 32'h8000_0050, 32'h0, 1'b0, 1'b0);
      push(SLV0, 1'b1, 1'b0, 32'h8000_0050, 32'h0, 1'b0, 1'b1);
      push(SLV1, 1'b0, 1'b0, 32'h8400_0060, 32'h0, 1'b0, 1'b0);
      push(SLV1, 1'b1, 1'b0, 32'h8400_0060, 32'h0, 1'b0, 1'b1);
      drv(1'b1, 1'b0, 32'h8000_0050, SLV0, 32'h0);
      drv(1'b0, 1'b0, 32'h8000_0050, SLV0, 32'h0);
      drv(1'b1, 1'b0, 32'h8400_0060, SLV1, 32'h0);
      repeat (2) drv(1'b0, 1'b0, 32'h0, 3'b000, 32'h0);

      // Reset asserted during RENABLE
      push(SLV0, 1'b0, 1'b0, 32'h8000_0030, 32'h0, 1'b0, 1'b0);
      push(SLV0, 1'b1, 1'b0, 32'h8000_0030, 32'h0, 1'b0, 1'b1);
      drv(1'b1, 1'b0, 32'h8000_0030, SLV0, 32'h0);
      drv(1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
      Hreset = 1'b1;
      drv(1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
      Hreset = 1'b0;
      check_reset_values();

      // Recovery read from IDLE after the abort
      push(SLV2, 1'b0, 1'b0, 32'h8800_0070, 32'h0, 1'b0, 1'b0);
      push(SLV2, 1'b1, 1'b0, 32'h8800_0070, 32'h0, 1'b0, 1'b1);
      drv(1'b1, 1'b0, 32'h8800_0070, SLV2, 32'h0);
      repeat (2) drv(1'b0, 1'b0, 32'h0, 3'b000, 32'h0);

`ifdef APB_PREADY_EN
      // Three wait states in WENABLE
      push(SLV1, 1'b0, 1'b1, 32'h8400_0008, 32'h0BAD_CAFE, 1'b1, 1'b1);
      push(SLV1, 1'b1, 1'b1, 32'h8400_0008, 32'h0BAD_CAFE, 1'b1, 1'b1);
      repeat (3) push(SLV1, 1'b1, 1'b1, 32'h8400_0008, 32'h0BAD_CAFE, 1'b1, 1'b0);
      drv(1'b1, 1'b1, 32'h8400_0008, SLV1, 32'h0);
      drv(1'b0, 1'b0, 32'h8400_0008, SLV1, 32'h0BAD_CAFE);
      drv(1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
      Pready = 1'b0;
      repeat (3) drv(1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
      Pready = 1'b1;
      drv(1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
      check("pready_idle_psel", Pselx, 3'b000);
`endif

      repeat (2) drv(1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
      check("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
